// File: rtl/time_adjust_ctrl.sv
// time_adjust_ctrl: four push-buttons -> mode, time/date select, adjust values and
// digit blink mask for the time/date counter. Key debounce is compiled in with
// `define KEY_DEBOUNCE_EN (DEB_CYCLES consecutive cycles to accept a level change).

// Per-key front end: 2-FF synchronizer, optional debounce, press (falling) detector.
module time_adjust_ctrl_key #(
   parameter int unsigned DEB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_key_n,
   output logic o_press
);
   logic [1:0] r_sync;
   logic [1:0] r_vld;
   logic       r_arm;
   logic       r_prev;
   logic       w_lvl;

   // two-stage synchronizer, idles at the released level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sync <= 2'b11;
      else        r_sync <= {r_sync[0], i_key_n};
   end

   // arm only once a genuine released level has come through the synchronizer,
   // so a key already held at reset release cannot fire
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= 2'b00;
         r_arm <= 1'b0;
      end else begin
         r_vld <= {r_vld[0], 1'b1};
         if (r_vld[1] && r_sync[1]) r_arm <= 1'b1;
      end
   end

`ifdef KEY_DEBOUNCE_EN
   localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
   logic [CW-1:0] r_cnt;
   logic          r_deb;

   // accept a new level only after DEB_CYCLES consecutive differing samples
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_deb <= 1'b1;
      end else if (r_sync[1] == r_deb) begin
         r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
         r_cnt <= '0;
         r_deb <= r_sync[1];
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end
   assign w_lvl = r_deb;
`else
   assign w_lvl = r_sync[1];
`endif

   // previous accepted level for the falling-edge detector
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_prev <= 1'b1;
      else        r_prev <= w_lvl;
   end

   assign o_press = r_arm & r_prev & ~w_lvl;
endmodule

module time_adjust_ctrl #(
   parameter int unsigned DEB_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_mode_n,
   input  logic        key_ch_n,
   input  logic        key_sel_n,
   input  logic        key_inc_n,
   input  logic [23:0] time_num,
   input  logic [23:0] data_num,
   output logic [1:0]  model,
   output logic        date_time_ch,
   output logic [23:0] adjust_time_num,
   output logic [23:0] adjust_date_num,
   output logic [5:0]  blink_mask
);
   typedef enum logic [1:0] {S_CLK = 2'b00, S_SW = 2'b01, S_ALM = 2'b10, S_ADJ = 2'b11} state_t;

   state_t      r_state, w_state_nx;
   logic        r_dtc, w_dtc_nx;
   logic [1:0]  r_fld, w_fld_nx;
   logic [23:0] r_at, w_at_nx;
   logic [23:0] r_ad, w_ad_nx;
   logic [5:0]  r_blink, w_blink_nx;
   logic [3:0]  w_keys_n;
   logic [3:0]  w_press;   // [3] mode, [2] ch, [1] sel, [0] inc

   assign w_keys_n = {key_mode_n, key_ch_n, key_sel_n, key_inc_n};

   for (genvar k = 0; k < 4; k++) begin : g_key
      time_adjust_ctrl_key #(.DEB_CYCLES(DEB_CYCLES)) u_key (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_key_n (w_keys_n[k]),
         .o_press (w_press[k])
      );
   end

   // two-digit BCD increment; anything at or above the top wraps to the bottom
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo,
                                          input logic [7:0] hi);
      if (v >= hi)              return lo;
      else if (v[3:0] >= 4'd9)  return {v[7:4] + 4'd1, 4'd0};
      else                      return v + 8'd1;
   endfunction

   // last day of a BCD month, no leap years
   function automatic logic [7:0] day_max(input logic [7:0] m);
      case (m)
         8'h02:                      return 8'h28;
         8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
         default:                    return 8'h31;
      endcase
   endfunction

   // state and all outputs registered together
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_CLK;
         r_dtc   <= 1'b0;
         r_fld   <= 2'd2;
         r_at    <= 24'h235649;
         r_ad    <= 24'h201228;
         r_blink <= 6'b000000;
      end else begin
         r_state <= w_state_nx;
         r_dtc   <= w_dtc_nx;
         r_fld   <= w_fld_nx;
         r_at    <= w_at_nx;
         r_ad    <= w_ad_nx;
         r_blink <= w_blink_nx;
      end
   end

   // next state / edit logic, one pulse acts per cycle: mode > ch > sel > inc
   always_comb begin
      w_state_nx = r_state;
      w_dtc_nx   = r_dtc;
      w_fld_nx   = r_fld;
      w_at_nx    = r_at;
      w_ad_nx    = r_ad;
      w_blink_nx = 6'b000000;
      if (w_press[3]) begin
         case (r_state)
            S_CLK: w_state_nx = S_SW;
            S_SW:  w_state_nx = S_ALM;
            S_ALM: begin
               w_state_nx = S_ADJ;
               w_at_nx    = time_num;
               w_ad_nx    = data_num;
               w_dtc_nx   = 1'b0;
               w_fld_nx   = 2'd2;
            end
            default: w_state_nx = S_CLK;
         endcase
      end else if (r_state == S_ADJ) begin
         if (w_press[2]) begin
            // re-snapshot the side being entered so a stale value is never loaded
            w_dtc_nx = ~r_dtc;
            w_fld_nx = 2'd2;
            if (r_dtc) w_at_nx = time_num;
            else       w_ad_nx = data_num;
         end else if (w_press[1]) begin
            w_fld_nx = (r_fld == 2'd0) ? 2'd2 : r_fld - 2'd1;
         end else if (w_press[0]) begin
            if (!r_dtc) begin
               case (r_fld)
                  2'd2:    w_at_nx[23:16] = bcd_inc(r_at[23:16], 8'h00, 8'h23);
                  2'd1:    w_at_nx[15:8]  = bcd_inc(r_at[15:8],  8'h00, 8'h59);
                  default: w_at_nx[7:0]   = bcd_inc(r_at[7:0],   8'h00, 8'h59);
               endcase
            end else begin
               case (r_fld)
                  2'd2:    w_ad_nx[23:16] = bcd_inc(r_ad[23:16], 8'h00, 8'h99);
                  2'd1:    w_ad_nx[15:8]  = bcd_inc(r_ad[15:8],  8'h01, 8'h12);
                  default: w_ad_nx[7:0]   = bcd_inc(r_ad[7:0],   8'h01, day_max(r_ad[15:8]));
               endcase
            end
         end
      end
      if (w_state_nx == S_ADJ) begin
         case (w_fld_nx)
            2'd2:    w_blink_nx = 6'b110000;
            2'd1:    w_blink_nx = 6'b001100;
            default: w_blink_nx = 6'b000011;
         endcase
      end
   end

   assign model           = r_state;
   assign date_time_ch    = r_dtc;
   assign adjust_time_num = r_at;
   assign adjust_date_num = r_ad;
   assign blink_mask      = r_blink;
endmodule

// File: tb/tb_time_adjust_ctrl.sv
// Directed bench for time_adjust_ctrl: expected outputs queued as each key step is
// driven, popped and asserted when the step's output edge has passed.
module tb_time_adjust_ctrl;
   localparam int DEB = 4;
`ifdef KEY_DEBOUNCE_EN
   localparam int LAT = DEB + 3;
`else
   localparam int LAT = 3;
`endif
   localparam logic [3:0] KM = 4'b1000, KC = 4'b0100, KS = 4'b0010, KI = 4'b0001;

   logic        clk = 1'b0, rst_n = 1'b1;
   logic        key_mode_n = 1'b1, key_ch_n = 1'b1, key_sel_n = 1'b1, key_inc_n = 1'b1;
   logic [23:0] time_num = '0, data_num = '0;
   logic [1:0]  model;
   logic        date_time_ch;
   logic [23:0] adjust_time_num, adjust_date_num;
   logic [5:0]  blink_mask;

   typedef struct packed {
      logic [1:0]  m;
      logic        dtc;
      logic [23:0] at;
      logic [23:0] ad;
      logic [5:0]  bl;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   time_adjust_ctrl #(.DEB_CYCLES(DEB)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .key_mode_n      (key_mode_n),
      .key_ch_n        (key_ch_n),
      .key_sel_n       (key_sel_n),
      .key_inc_n       (key_inc_n),
      .time_num        (time_num),
      .data_num        (data_num),
      .model           (model),
      .date_time_ch    (date_time_ch),
      .adjust_time_num (adjust_time_num),
      .adjust_date_num (adjust_date_num),
      .blink_mask      (blink_mask)
   );

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input logic [1:0] m, input logic dtc, input logic [23:0] at,
                             input logic [23:0] ad, input logic [5:0] bl);
      exp_t e;
      e = '{m: m, dtc: dtc, at: at, ad: ad, bl: bl};
      sb.push_back(e);
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      n_assert++;
      assert (sb.size() != 0) else begin
         n_fail++;
         $error("FAIL %s: observed empty scoreboard expected an entry", tag);
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, ".model"}, 24'(model),        24'(e.m));
         chk({tag, ".dtc"},   24'(date_time_ch), 24'(e.dtc));
         chk({tag, ".atime"}, adjust_time_num,   e.at);
         chk({tag, ".adate"}, adjust_date_num,   e.ad);
         chk({tag, ".blink"}, 24'(blink_mask),   24'(e.bl));
      end
   endtask

   task automatic drive_keys(input logic [3:0] k);
      key_mode_n = ~k[3];
      key_ch_n   = ~k[2];
      key_sel_n  = ~k[1];
      key_inc_n  = ~k[0];
   endtask

   task automatic release_keys();
      @(negedge clk);
      drive_keys(4'b0000);
      repeat (LAT + 2) @(posedge clk);
      #1;
   endtask

   // press keys, check on the output edge, optionally keep holding and re-check
   task automatic step(input string tag, input logic [3:0] k, input int hold,
                       input logic [1:0] m, input logic dtc, input logic [23:0] at,
                       input logic [23:0] ad, input logic [5:0] bl);
      expect_out(m, dtc, at, ad, bl);
      @(negedge clk);
      drive_keys(k);
      repeat (LAT) @(posedge clk);
      #1;
      check_out(tag);
      if (hold > 0) begin
         expect_out(m, dtc, at, ad, bl);
         repeat (hold) @(posedge clk);
         #1;
         check_out({tag, "_held"});
      end
      release_keys();
   endtask

   initial begin
      // reset
      #2 rst_n = 1'b0;
      #1;
      expect_out(2'b00, 1'b0, 24'h235649, 24'h201228, 6'b000000);
      check_out("reset");
      @(negedge clk) rst_n = 1'b1;
      repeat (5) @(posedge clk);

      // mode cycle, with exact latency on the first press
      time_num = 24'h101530;
      data_num = 24'h200101;
      expect_out(2'b01, 1'b0, 24'h235649, 24'h201228, 6'b000000);
      @(negedge clk);
      drive_keys(KM);
      repeat (LAT - 1) @(posedge clk);
      #1;
      chk("latency_early", 24'(model), 24'h0);
      @(posedge clk);
      #1;
      check_out("mode1");
      release_keys();
      step("mode2", KM, 0, 2'b10, 1'b0, 24'h235649, 24'h201228, 6'b000000);
      step("mode3", KM, 0, 2'b11, 1'b0, 24'h101530, 24'h200101, 6'b110000);
      step("mode4", KM, 0, 2'b00, 1'b0, 24'h101530, 24'h200101, 6'b000000);

      // time wraps
      time_num = 24'h235909;
      step("t_sw",   KM, 0, 2'b01, 1'b0, 24'h101530, 24'h200101, 6'b000000);
      step("t_alm",  KM, 0, 2'b10, 1'b0, 24'h101530, 24'h200101, 6'b000000);
      step("t_adj",  KM, 0, 2'b11, 1'b0, 24'h235909, 24'h200101, 6'b110000);
      step("hr_inc", KI, 0, 2'b11, 1'b0, 24'h005909, 24'h200101, 6'b110000);
      step("sel1",   KS, 0, 2'b11, 1'b0, 24'h005909, 24'h200101, 6'b001100);
      step("mn_inc", KI, 0, 2'b11, 1'b0, 24'h000009, 24'h200101, 6'b001100);
      step("sel0",   KS, 0, 2'b11, 1'b0, 24'h000009, 24'h200101, 6'b000011);
      step("sc_inc", KI, 0, 2'b11, 1'b0, 24'h000010, 24'h200101, 6'b000011);
      step("sel2",   KS, 0, 2'b11, 1'b0, 24'h000010, 24'h200101, 6'b110000);

      // date wraps
      data_num = 24'h210228;
      step("ch_date", KC, 0, 2'b11, 1'b1, 24'h000010, 24'h210228, 6'b110000);
      step("d_sel1",  KS, 0, 2'b11, 1'b1, 24'h000010, 24'h210228, 6'b001100);
      step("d_sel0",  KS, 0, 2'b11, 1'b1, 24'h000010, 24'h210228, 6'b000011);
      step("feb28",   KI, 0, 2'b11, 1'b1, 24'h000010, 24'h210201, 6'b000011);
      time_num = 24'h123456;
      data_num = 24'h991231;
      step("ch_time", KC, 0, 2'b11, 1'b0, 24'h123456, 24'h210201, 6'b110000);
      step("ch_dat2", KC, 0, 2'b11, 1'b1, 24'h123456, 24'h991231, 6'b110000);
      step("yr99",    KI, 0, 2'b11, 1'b1, 24'h123456, 24'h001231, 6'b110000);
      step("d_sel1b", KS, 0, 2'b11, 1'b1, 24'h123456, 24'h001231, 6'b001100);
      step("mon12",   KI, 0, 2'b11, 1'b1, 24'h123456, 24'h000131, 6'b001100);
      step("d_sel0b", KS, 0, 2'b11, 1'b1, 24'h123456, 24'h000131, 6'b000011);
      step("jan31",   KI, 0, 2'b11, 1'b1, 24'h123456, 24'h000101, 6'b000011);

      // edit keys ignored outside ADJ
      step("leave",   KM, 0, 2'b00, 1'b1, 24'h123456, 24'h000101, 6'b000000);
      step("ign_inc", KI, 0, 2'b00, 1'b1, 24'h123456, 24'h000101, 6'b000000);
      step("ign_sel", KS, 0, 2'b00, 1'b1, 24'h123456, 24'h000101, 6'b000000);
      step("ign_ch",  KC, 0, 2'b00, 1'b1, 24'h123456, 24'h000101, 6'b000000);

      // long hold gives a single step; then priority mode over inc
      step("hold",    KM, 100, 2'b01, 1'b1, 24'h123456, 24'h000101, 6'b000000);
      step("p_alm",   KM, 0,   2'b10, 1'b1, 24'h123456, 24'h000101, 6'b000000);
      step("p_adj",   KM, 0,   2'b11, 1'b0, 24'h123456, 24'h991231, 6'b110000);
      step("prio",    KM | KI, 0, 2'b00, 1'b0, 24'h123456, 24'h991231, 6'b000000);

      // reset mid-edit with a key held through reset release
      step("r_sw",    KM, 0, 2'b01, 1'b0, 24'h123456, 24'h991231, 6'b000000);
      step("r_alm",   KM, 0, 2'b10, 1'b0, 24'h123456, 24'h991231, 6'b000000);
      step("r_adj",   KM, 0, 2'b11, 1'b0, 24'h123456, 24'h991231, 6'b110000);
      step("r_inc",   KI, 0, 2'b11, 1'b0, 24'h133456, 24'h991231, 6'b110000);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      drive_keys(KM);
      #1;
      expect_out(2'b00, 1'b0, 24'h235649, 24'h201228, 6'b000000);
      check_out("rst_async");
      @(negedge clk) rst_n = 1'b1;
      repeat (LAT + 10) @(posedge clk);
      #1;
      expect_out(2'b00, 1'b0, 24'h235649, 24'h201228, 6'b000000);
      check_out("rst_keyheld");
      release_keys();
      step("post_rst", KM, 0, 2'b01, 1'b0, 24'h235649, 24'h201228, 6'b000000);

`ifdef KEY_DEBOUNCE_EN
      // short glitches rejected, steady press lands on edge DEB+3
      for (int g = 0; g < 3; g++) begin
         @(negedge clk) key_mode_n = 1'b0;
         repeat (DEB - 1) @(negedge clk);
         key_mode_n = 1'b1;
         repeat (DEB + 2) @(negedge clk);
      end
      chk("glitch", 24'(model), 24'h1);
      @(negedge clk) key_mode_n = 1'b0;
      repeat (DEB + 2) @(posedge clk);
      #1;
      chk("deb_early", 24'(model), 24'h1);
      @(posedge clk);
      #1;
      chk("deb_edge", 24'(model), 24'h2);
      release_keys();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/time_adjust_ctrl.md
# time_adjust_ctrl

Front-panel controller that sits directly upstream of the time/date counter. It turns four push-buttons into the counter's `model`, `date_time_ch`, `adjust_time_num` and `adjust_date_num` inputs. In adjust mode it snapshots the running time or date, lets the user select and increment one BCD field at a time with legal wrap-around, and drives a digit blink mask for the display stage.

## Interface
Parameters:
- `DEB_CYCLES`, default 1_000_000: consecutive stable clk cycles (20 ms at 50 MHz) needed to accept a key level change. Used only when debounce is compiled in.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_mode_n` in 1: mode key, active-low, asynchronous to `clk`.
- `key_ch_n` in 1: time/date toggle key, active-low.
- `key_sel_n` in 1: field select key, active-low.
- `key_inc_n` in 1: increment key, active-low.
- `time_num` in 24: live hhmmss BCD from the counter.
- `data_num` in 24: live yymmdd BCD from the counter.
- `model` out 2: mode. 00 clock, 01 stopwatch, 10 alarm, 11 adjust.
- `date_time_ch` out 1: 0 = editing time, 1 = editing date.
- `adjust_time_num` out 24: hhmmss BCD loaded by the counter while `model`=11 and `date_time_ch`=0.
- `adjust_date_num` out 24: yymmdd BCD loaded while `model`=11 and `date_time_ch`=1.
- `blink_mask` out 6: one bit per display digit [5:0]. Bits are set for the two digits of the selected field while `model`=11, else 0.

## Operation
- **Key front end:** each key goes through a 2-FF synchronizer and then a press detector. The detector emits a one-cycle pulse on the accepted high-to-low transition. Releases produce no pulse.
- **Mode FSM:** states CLK(00), SW(01), ALM(10), ADJ(11).
  - A `mode` pulse advances CLK→SW→ALM→ADJ→CLK.
  - Entering ADJ: capture `time_num` into `adjust_time_num` and `data_num` into `adjust_date_num`; set `date_time_ch`=0 and field=2.
  - Leaving ADJ: `adjust_*` hold their values; `blink_mask` goes to 0.
- **ch, sel and inc pulses** are ignored outside ADJ.
- **ch pulse in ADJ:** toggles `date_time_ch`, resets field to 2, and re-captures the side being entered. Toggling to time copies `time_num`; toggling to date copies `data_num`. This prevents a stale value being loaded after the other side has kept running.
- **sel pulse:** field cycles 2→1→0→2. Field 2 = hours/year [23:16], 1 = minutes/month [15:8], 0 = seconds/day [7:0].
- **inc pulse:** increments the selected two-digit BCD field of the active register by one.
  - Low digit 9 carries into the high digit.
  - Wrap ranges: hours 00–23→00; min/sec 00–59→00; year 00–99→00; month 01–12→01; day 01–max(month)→01.
  - Month maxima (no leap year): Feb 28; Apr, Jun, Sep, Nov 30; all others 31.
- **Field encodings:** all outputs stay valid BCD at all times. Every increment result uses hours≤23, month 01–12 and day≥01.
- **Simultaneous pulses in one cycle:** only the highest-priority pulse acts. Priority is mode > ch > sel > inc.
- **blink_mask** in ADJ: field 2 → 110000, field 1 → 001100, field 0 → 000011.

## Timing
- Reset values:
  - `model`=00, `date_time_ch`=0, field=2, `blink_mask`=000000.
  - `adjust_time_num`=24'h235649, `adjust_date_num`=24'h201228 (match the counter's reset defaults).
  - All synchronizer and debounce state idle (released).
- All outputs are registered.
- Key-to-output latency:
  - With debounce: a key held low continuously changes outputs on the (DEB_CYCLES+3)th clk edge after the falling edge.
  - Without debounce: on the 3rd edge.
- Snapshot on ADJ entry or ch toggle samples `time_num`/`data_num` on the same edge the state changes.
- Bounce shorter than DEB_CYCLES: no pulse. Key held indefinitely: exactly one pulse, no auto-repeat.
- Reset asserted mid-press or mid-edit: immediate return to reset values. Releasing reset with a key already low produces no pulse until the key is released and pressed again.

## Configuration
- `KEY_DEBOUNCE_EN`:
  - Defined: per-key counter up to DEB_CYCLES. The debounced level flips only after DEB_CYCLES consecutive cycles of differing synchronized input.
  - Undefined: the synchronized level feeds the edge detector directly, for benches with clean stimulus. `DEB_CYCLES` is unused.

## Test plan
- **Mode cycle:** after reset, 4 `mode` presses → `model` goes 01, 10, 11, 00. Entering 11 with `time_num`=24'h101530 → `adjust_time_num`=24'h101530, `blink_mask`=110000.
- **Time wrap:** in ADJ/time with hours=23, inc → 00. sel, then min=59, inc → 00. sel, then sec=09, inc → 10, `blink_mask`=000011.
- **Date wrap:** ch toggles to date and `adjust_date_num` re-captures `data_num`=24'h210228. Day field inc → 24'h210201. Month=12, inc → 01. Year=99, inc → 00.
- **Debounce** (`KEY_DEBOUNCE_EN`, DEB_CYCLES=4):
  - 3-cycle low glitches → no change.
  - Steady press → `model` changes on edge 7.
  - Held for 100 cycles → single step.
- **Priority:** mode and inc pressed in the same cycle while in ADJ → `model`=00, `adjust_*` unchanged.
- **Reset mid-edit:** `rst_n` low during ADJ → all outputs return to reset values in the same cycle, asynchronously.
